// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and byte width for the UART transmit arbiter
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} arb_state_t;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester byte streams and transceiver strobes shared by the arbiter
interface uart_tx_arb_if #(parameter int NUM_REQ = 2);
  import uart_pkg::*;
  logic [NUM_REQ-1:0] req_valid_i;
  logic [NUM_REQ-1:0][UART_BYTE_W-1:0] req_data_i;
  logic [NUM_REQ-1:0] req_last_i;
  logic [NUM_REQ-1:0] req_ready_o;
  logic [UART_BYTE_W-1:0] tx_data_o;
  logic tx_wr_o;
  logic tx_done_i;
  logic [NUM_REQ-1:0] grant_o;
  logic busy_o;
  logic err_o;
  modport master (
    output req_valid_i, req_data_i, req_last_i, tx_done_i,
    input  req_ready_o, tx_data_o, tx_wr_o, grant_o, busy_o, err_o
  );
  modport slave (
    input  req_valid_i, req_data_i, req_last_i, tx_done_i,
    output req_ready_o, tx_data_o, tx_wr_o, grant_o, busy_o, err_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick of the first request at or after the pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);
  logic [IW-1:0] w_j;
  // Scan from the farthest offset back to the pointer so the nearest requester wins
  always_comb begin
    o_idx = '0;
    w_j = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_j = IW'((int'(i_ptr) + i) % NUM_REQ);
      o_idx = i_req[w_j] ? w_j : o_idx;
    end
  end
  assign o_any = |i_req;
  assign o_gnt = o_any ? NUM_REQ'(1) << o_idx : '0;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: frame-level round-robin sharing of one UART transmitter; optional stall abort under UART_TX_ARB_TIMEOUT_EN
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int          NUM_REQ      = 2,
  parameter logic [15:0] IDLE_TIMEOUT = 16'd65535
) (
  input logic         clk,
  input logic         rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;

  logic [1:0]             r_state;
  logic [NUM_REQ-1:0]     r_grant;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_ptr;
  logic [UART_BYTE_W-1:0] r_tx_data;
  logic                   r_tx_wr;
  logic                   r_last;
  logic                   r_busy;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [IW-1:0]          w_idx;
  logic [IW-1:0]          w_next_ptr;
  logic                   w_any;
  logic                   w_issue;
  logic                   w_hs;
  logic                   w_frame_end;
  logic                   w_abort;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req(bus.req_valid_i),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  assign w_issue     = r_state == S_ISSUE;
  assign w_hs        = w_issue && bus.req_valid_i[r_idx];
  assign w_frame_end = r_state == S_WAIT && bus.tx_done_i && r_last;
  assign w_next_ptr  = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + IW'(1);

  assign bus.req_ready_o = w_issue ? (r_grant & bus.req_valid_i) : '0;
  assign bus.tx_data_o   = r_tx_data;
  assign bus.tx_wr_o     = r_tx_wr;
  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = r_busy;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_err;
  assign w_abort   = w_issue && !w_hs && (r_cnt + 16'd1 == IDLE_TIMEOUT);
  assign bus.err_o = r_err;
  // Count consecutive owner stall cycles in ISSUE; any other cycle restarts the count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= (w_issue && !w_hs && !w_abort) ? r_cnt + 16'd1 : '0;
      r_err <= r_err | w_abort;
    end
  end
`else
  logic w_unused;
  assign w_abort   = 1'b0;
  assign w_unused  = ^IDLE_TIMEOUT;
  assign bus.err_o = 1'b0;
`endif

  // Grant, byte issue, done pacing and pointer rotation; frame end or abort releases the line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_idx     <= '0;
      r_ptr     <= '0;
      r_tx_data <= '0;
      r_tx_wr   <= 1'b0;
      r_last    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_tx_wr <= w_hs;
      if (r_state == S_IDLE && w_any) begin
        r_state <= S_ISSUE;
        r_grant <= w_gnt;
        r_idx   <= w_idx;
        r_busy  <= 1'b1;
      end
      if (w_hs) begin
        r_state   <= S_WAIT;
        r_tx_data <= bus.req_data_i[r_idx];
        r_last    <= bus.req_last_i[r_idx];
      end
      if (r_state == S_WAIT && bus.tx_done_i && !r_last)
        r_state <= S_ISSUE;
      if (w_frame_end || w_abort) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_busy  <= 1'b0;
        r_ptr   <= w_next_ptr;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: randomized requesters and transceiver against a frame-level arbitration model
module tb_uart_tx_arb;
  localparam int N = 3;
  localparam logic [15:0] TO = 16'd20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [8:0] fifo [N][1024];
  int wp [N];
  int rp [N];
  int done_dly = -1;
  int gap_pct = 0;
  int man_req = 0;
  int man_ack = 0;
  bit force_all = 1'b0;
  logic [7:0] line [$];
  logic [7:0] exp_q [$];

  uart_tx_arb_if #(.NUM_REQ(N)) bus ();
  uart_tx_arb #(.NUM_REQ(N), .IDLE_TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester queues and transceiver: handshakes pop bytes, each write is answered by a done pulse
  initial begin
    logic [N-1:0] hs;
    logic [8:0] e;
    bit wr, auto_done, has;
    int cnt;
    cnt = 0;
    bus.req_valid_i = '0;
    bus.req_data_i = '0;
    bus.req_last_i = '0;
    bus.tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      hs = rst_n ? (bus.req_ready_o & bus.req_valid_i) : '0;
      wr = rst_n && (bus.tx_wr_o === 1'b1);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) if (hs[k]) rp[k]++;
      if (!rst_n) cnt = 0;
      else if (wr) cnt = (done_dly < 0) ? int'($urandom_range(9, 2)) : done_dly;
      auto_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        auto_done = (cnt == 0);
      end
      bus.tx_done_i = auto_done || (man_req != man_ack);
      man_ack = man_req;
      for (int k = 0; k < N; k++) begin
        has = rp[k] != wp[k];
        e = fifo[k][rp[k] % 1024];
        bus.req_valid_i[k] = force_all || (has && ($urandom_range(99, 0) >= gap_pct));
        bus.req_data_i[k] = has ? e[7:0] : 8'h00;
        bus.req_last_i[k] = has && e[8];
      end
    end
  end

  // Frame-level model: one owner at a time, at most one byte on the line, pointer moves past the finished owner
  initial begin
    int owner, ptr, stall;
    bit infl, last, wr, err;
    logic [7:0] data;
    logic [N-1:0] v, eg;
    owner = -1; ptr = 0; stall = 0; infl = 0; last = 0; wr = 0; err = 0; data = 8'h00;
    forever begin
      @(negedge clk);
      v = bus.req_valid_i;
      eg = (owner < 0) ? '0 : N'(1) << owner;
      chk("grant", bus.grant_o, eg);
      chk("busy", bus.busy_o, owner >= 0);
      chk("ready", bus.req_ready_o, (owner >= 0 && !infl) ? (v & eg) : '0);
      chk("tx_wr", bus.tx_wr_o, wr);
      chk("tx_data", bus.tx_data_o, data);
      chk("err", bus.err_o, err);
      if (bus.tx_wr_o === 1'b1) line.push_back(bus.tx_data_o);
      wr = 0;
      if (!rst_n) begin
        owner = -1; ptr = 0; stall = 0; infl = 0; last = 0; data = 8'h00; err = 0;
      end else if (owner < 0) begin
        for (int i = 0; i < N; i++) if (owner < 0 && v[(ptr + i) % N]) owner = (ptr + i) % N;
      end else if (!infl) begin
        if (v[owner]) begin
          data = bus.req_data_i[owner];
          last = bus.req_last_i[owner];
          infl = 1;
          wr = 1;
          stall = 0;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else begin
          stall++;
          if (stall == int'(TO)) begin
            ptr = (owner + 1) % N;
            owner = -1;
            err = 1;
            stall = 0;
          end
        end
`endif
      end else if (bus.tx_done_i) begin
        infl = 0;
        if (last) begin
          ptr = (owner + 1) % N;
          owner = -1;
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int k, logic [7:0] b, bit l);
    fifo[k][wp[k] % 1024] = {l, b};
    wp[k]++;
  endtask

  function automatic bit drained();
    for (int k = 0; k < N; k++) if (rp[k] != wp[k]) return 1'b0;
    return bus.busy_o === 1'b0;
  endfunction

  task automatic wait_idle(int lim);
    int i;
    for (i = 0; i < lim && !drained(); i++) tick(1);
    chk("drain_timeout", i < lim, 1);
    tick(2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic chk_line(string name, int base);
    chk({name, "_len"}, line.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < line.size()) chk(name, line[base + i], exp_q[i]);
  endtask

  initial begin
    int base, n, len, tot, k;
    rst_n = 1'b0;
    force_all = 1'b1;
    tick(3);
    @(negedge clk);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_ready", bus.req_ready_o, 0);
    chk("rst_tx_wr", bus.tx_wr_o, 0);
    chk("rst_tx_data", bus.tx_data_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_no_writes", line.size(), 0);
    force_all = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    done_dly = 10;
    base = line.size();
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    wait_idle(300);
    exp_q = {8'h41, 8'h42, 8'h43};
    chk_line("single", base);
    chk("single_released", bus.grant_o, 0);

    do_reset();
    done_dly = -1;
    base = line.size();
    push(0, 8'hA0, 0); push(0, 8'hA1, 1);
    push(1, 8'hB0, 0); push(1, 8'hB1, 1);
    wait_idle(400);
    exp_q = {8'hA0, 8'hA1, 8'hB0, 8'hB1};
    chk_line("contend", base);
    base = line.size();
    push(0, 8'hC0, 1); push(1, 8'hD0, 1);
    wait_idle(400);
    exp_q = {8'hC0, 8'hD0};
    chk_line("contend_after_req1", base);
    base = line.size();
    push(0, 8'hE0, 1);
    wait_idle(400);
    base = line.size();
    push(0, 8'hF0, 1); push(1, 8'hF1, 1);
    wait_idle(400);
    exp_q = {8'hF1, 8'hF0};
    chk_line("contend_after_req0", base);

    done_dly = 10;
    base = line.size();
    push(0, 8'h51, 0); push(0, 8'h52, 0); push(0, 8'h53, 1);
    for (n = 0; n < 200 && line.size() < base + 2; n++) tick(1);
    chk("mid_second_byte", n < 200, 1);
    push(1, 8'h61, 1);
    wait_idle(400);
    exp_q = {8'h51, 8'h52, 8'h53, 8'h61};
    chk_line("midframe", base);

`ifdef UART_TX_ARB_TIMEOUT_EN
    do_reset();
    done_dly = 4;
    base = line.size();
    push(0, 8'h71, 0); push(1, 8'h81, 1);
    wait_idle(400);
    exp_q = {8'h71, 8'h81};
    chk_line("timeout", base);
    chk("timeout_err", bus.err_o, 1);
    do_reset();
    chk("timeout_err_cleared", bus.err_o, 0);
`else
    done_dly = 4;
    base = line.size();
    push(0, 8'h71, 0);
    tick(60);
    chk("stall_grant", bus.grant_o, 1);
    chk("stall_busy", bus.busy_o, 1);
    push(0, 8'h72, 1);
    wait_idle(200);
    exp_q = {8'h71, 8'h72};
    chk_line("stall", base);
`endif

    done_dly = -1;
    push(0, 8'hA5, 1);
    wait_idle(200);
    done_dly = 0;
    base = line.size();
    push(1, 8'h92, 0);
    for (n = 0; n < 200 && line.size() <= base; n++) tick(1);
    chk("rstmid_written", n < 200, 1);
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    man_req++;
    tick(3);
    chk("rstmid_busy", bus.busy_o, 0);
    chk("rstmid_grant", bus.grant_o, 0);
    done_dly = -1;
    base = line.size();
    push(0, 8'hB1, 1); push(1, 8'hB2, 1);
    wait_idle(400);
    exp_q = {8'hB1, 8'hB2};
    chk_line("rstmid_ptr0", base);

    do_reset();
    gap_pct = 20;
    base = line.size();
    tot = 0;
    repeat (40) begin
      k = int'($urandom_range(N - 1, 0));
      len = int'($urandom_range(4, 1));
      for (int i = 0; i < len; i++) push(k, 8'($urandom), i == len - 1);
      tot += len;
      tick(int'($urandom_range(15, 0)));
    end
    wait_idle(20000);
    chk("random_bytes", line.size() - base, tot);
    gap_pct = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
